// File: rtl/cdb_arbiter_rr.sv
// Round-robin common data bus arbiter.
// Each functional unit pushes {tag, data} results into a private FIFO; one
// FIFO head per cycle is broadcast on the registered bus. The search for the
// winner starts at a rotating pointer, so every busy channel gets served.

// Per-channel result FIFO. Memory is unreset; only occupancy/pointers are.
module cdb_arbiter_rr_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    do_push;
    logic                    do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO refuses a push even when it pops on the same edge.
    // Flush overrides both sides.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    assign head = mem[rd_ptr];

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module cdb_arbiter_rr #(
    parameter int NUM_CH     = 4,
    parameter int TAG_W      = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_CH-1:0]                req_in,
    input  logic [NUM_CH*(TAG_W+DATA_W)-1:0] data_in,
    output logic [NUM_CH-1:0]                ready_out,
    output logic [TAG_W+DATA_W:0]            cdb,
    output logic [NUM_CH-1:0]                grant
);
    localparam int ENT_W = TAG_W + DATA_W;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct packed {
        logic   vld;
        entry_t ent;
    } beat_t;

    entry_t [NUM_CH-1:0] head;
    logic   [NUM_CH-1:0] empty;
    logic   [NUM_CH-1:0] full;
    logic   [NUM_CH-1:0] win_onehot;
    logic   [PTR_W-1:0]  rr_ptr;
    logic   [PTR_W-1:0]  win_idx;
    logic   [PTR_W-1:0]  next_ptr;
    logic   [PTR_W-1:0]  scan_sel;
    logic                win_found;
    int                  scan_idx;
    beat_t               bus_q;

    // One FIFO per channel; the winner's onehot bit doubles as its pop strobe.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cdb_arbiter_rr_fifo #(
            .W     (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (req_in[k]),
            .pop   (win_onehot[k]),
            .wdata (data_in[k*ENT_W +: ENT_W]),
            .head  (head[k]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

    // Ready depends on occupancy only, never on this cycle's pop.
    assign ready_out = ~full;

    // Rotating priority scan: p, p+1, ..., wrapping; first non-empty wins.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
            scan_sel = PTR_W'(scan_idx);
            if (!win_found && !empty[scan_sel]) begin
                win_found            = 1'b1;
                win_idx              = scan_sel;
                win_onehot[scan_sel] = 1'b1;
            end
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;

    // Registered bus beat, grant and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q  <= '0;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            // Drop the beat but keep the pointer so fairness carries on.
            bus_q <= '0;
            grant <= '0;
        end else begin
            bus_q.vld <= win_found;
            bus_q.ent <= win_found ? head[win_idx] : '0;
            grant     <= win_onehot;
            if (win_found) rr_ptr <= next_ptr;
        end
    end

    assign cdb = bus_q;
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Directed bench for cdb_arbiter_rr with hand-computed expected beats.
module tb_cdb_arbiter_rr;
    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   req_in;
    logic [159:0] data_in;
    logic [3:0]   ready_out;
    logic [40:0]  cdb;
    logic [3:0]   grant;

    int passed;
    int total;

    cdb_arbiter_rr #(
        .NUM_CH     (4),
        .TAG_W      (8),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_in    (req_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .cdb       (cdb),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [40:0] beat(input logic [7:0] tag, input logic [31:0] data);
        return {1'b1, tag, data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic setd(input int k, input logic [7:0] tag, input logic [31:0] data);
        data_in[k*40 +: 40] = {tag, data};
    endtask

    // Advance past one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [40:0] exp_cdb, input logic [3:0] exp_grant);
        chk({tag, "_cdb"}, 64'(cdb), 64'(exp_cdb));
        chk({tag, "_grant"}, 64'(grant), 64'(exp_grant));
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        req_in  = '0;
        data_in = '0;
        #2;
        chk("rst_cdb", 64'(cdb), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ready", 64'(ready_out), 64'hF);

        // Pushes during reset must be ignored.
        req_in = 4'b0001;
        setd(0, 8'hDD, 32'h0000DEAD);
        tick; tick;
        req_in = '0;
        rst    = 1'b0;
        tick;
        chk_beat("rst_push_ignored", '0, 4'b0000);

        // 1: single push on ch1
        req_in = 4'b0010;
        setd(1, 8'h42, 32'h000000A6);
        tick;
        req_in = '0;
        chk_beat("t1_lat", '0, 4'b0000);
        tick;
        chk_beat("t1_beat", 41'h1_42_000000A6, 4'b0010);
        tick;
        chk_beat("t1_idle", '0, 4'b0000);

        // Restart pointer at 0 for the all-channel burst.
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // 2: all four channels at once
        for (int k = 0; k < 4; k++) setd(k, 8'(8'h10 + k), 32'(32'h10 + k));
        req_in = 4'hF;
        tick;
        req_in = '0;
        chk_beat("t2_lat", '0, 4'b0000);
        tick; chk_beat("t2_b0", beat(8'h10, 32'h10), 4'b0001);
        tick; chk_beat("t2_b1", beat(8'h11, 32'h11), 4'b0010);
        tick; chk_beat("t2_b2", beat(8'h12, 32'h12), 4'b0100);
        tick; chk_beat("t2_b3", beat(8'h13, 32'h13), 4'b1000);
        tick; chk_beat("t2_idle", '0, 4'b0000);

        // 3: ch0/ch1 stream, pointer at 0
        req_in = 4'b0011;
        setd(0, 8'hA0, 32'h100); setd(1, 8'hB0, 32'h200);
        tick;
        chk_beat("t3_e1", '0, 4'b0000);
        chk("t3_e1_ready", 64'(ready_out), 64'hF);
        setd(0, 8'hA0, 32'h101); setd(1, 8'hB0, 32'h201);
        tick;
        chk_beat("t3_e2", beat(8'hA0, 32'h100), 4'b0001);
        chk("t3_e2_ready", 64'(ready_out), 64'b1101);
        setd(0, 8'hA0, 32'h102); setd(1, 8'hB0, 32'h202);
        tick;
        chk_beat("t3_e3", beat(8'hB0, 32'h200), 4'b0010);
        chk("t3_e3_ready", 64'(ready_out), 64'b1110);
        setd(0, 8'hA0, 32'h103);
        tick;
        chk_beat("t3_e4", beat(8'hA0, 32'h101), 4'b0001);
        chk("t3_e4_ready", 64'(ready_out), 64'b1101);
        req_in = '0;
        tick; chk_beat("t3_e5", beat(8'hB0, 32'h201), 4'b0010);
        tick; chk_beat("t3_e6", beat(8'hA0, 32'h102), 4'b0001);
        tick; chk_beat("t3_e7", beat(8'hB0, 32'h202), 4'b0010);
        tick; chk_beat("t3_idle", '0, 4'b0000);

        // 4: ch2 full and popped while its request is held (pointer at 2)
        req_in = 4'b1100;
        setd(2, 8'hC2, 32'h300); setd(3, 8'hD3, 32'h400);
        tick;
        chk_beat("t4_e1", '0, 4'b0000);
        setd(2, 8'hC2, 32'h301); setd(3, 8'hD3, 32'h401);
        tick;
        chk_beat("t4_e2", beat(8'hC2, 32'h300), 4'b0100);
        chk("t4_e2_ready", 64'(ready_out), 64'b0111);
        req_in = 4'b0100;
        setd(2, 8'hC2, 32'h302);
        tick;
        chk_beat("t4_e3", beat(8'hD3, 32'h400), 4'b1000);
        chk("t4_e3_ready", 64'(ready_out), 64'b1011);
        setd(2, 8'hC2, 32'h303);
        tick;
        chk_beat("t4_e4", beat(8'hC2, 32'h301), 4'b0100);
        chk("t4_e4_ready", 64'(ready_out), 64'b1111);
        tick;
        chk_beat("t4_e5", beat(8'hD3, 32'h401), 4'b1000);
        chk("t4_e5_ready", 64'(ready_out), 64'b1011);
        req_in = '0;
        tick; chk_beat("t4_e6", beat(8'hC2, 32'h302), 4'b0100);
        tick; chk_beat("t4_e7", beat(8'hC2, 32'h303), 4'b0100);
        tick; chk_beat("t4_idle", '0, 4'b0000);

        // 5: flush with three queued results and a live beat (pointer at 3)
        req_in = 4'b1001;
        setd(0, 8'hE0, 32'h500); setd(3, 8'hF3, 32'h600);
        tick;
        chk_beat("t5_e1", '0, 4'b0000);
        setd(0, 8'hE0, 32'h501); setd(3, 8'hF3, 32'h601);
        tick;
        chk_beat("t5_e2", beat(8'hF3, 32'h600), 4'b1000);
        req_in = 4'b1000;
        setd(3, 8'hF3, 32'h602);
        tick;
        chk_beat("t5_e3", beat(8'hE0, 32'h500), 4'b0001);
        flush  = 1'b1;
        req_in = 4'b0010;
        setd(1, 8'hEE, 32'h00000BAD);
        tick;
        chk_beat("t5_flush", '0, 4'b0000);
        chk("t5_flush_ready", 64'(ready_out), 64'hF);
        flush  = 1'b0;
        req_in = '0;
        tick;
        chk_beat("t5_post", '0, 4'b0000);
        // Pointer kept at 1 across flush: ch3 beats ch0.
        req_in = 4'b1001;
        setd(0, 8'h70, 32'h700); setd(3, 8'h73, 32'h703);
        tick;
        req_in = '0;
        chk_beat("t5_e6", '0, 4'b0000);
        tick; chk_beat("t5_e7", beat(8'h73, 32'h703), 4'b1000);
        tick; chk_beat("t5_e8", beat(8'h70, 32'h700), 4'b0001);
        tick; chk_beat("t5_idle", '0, 4'b0000);

        // 6: asynchronous reset mid-burst (pointer at 1)
        for (int k = 0; k < 4; k++) setd(k, 8'(8'h80 + k), 32'(32'h800 + k));
        req_in = 4'hF;
        tick;
        req_in = '0;
        chk_beat("t6_e1", '0, 4'b0000);
        tick; chk_beat("t6_e2", beat(8'h81, 32'h801), 4'b0010);
        tick; chk_beat("t6_e3", beat(8'h82, 32'h802), 4'b0100);
        #3;
        rst = 1'b1;
        #1;
        chk_beat("t6_async", '0, 4'b0000);
        #2;
        rst = 1'b0;
        tick;
        chk_beat("t6_discard", '0, 4'b0000);
        chk("t6_ready", 64'(ready_out), 64'hF);
        // Pointer back at 0: ch1 ahead of ch3.
        req_in = 4'b1010;
        setd(1, 8'h91, 32'h901); setd(3, 8'h93, 32'h903);
        tick;
        req_in = '0;
        chk_beat("t6_lat", '0, 4'b0000);
        tick; chk_beat("t6_b1", beat(8'h91, 32'h901), 4'b0010);
        tick; chk_beat("t6_b3", beat(8'h93, 32'h903), 4'b1000);
        tick; chk_beat("t6_idle", '0, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
